// File: rtl/tq_zigzag_scan.sv
// tq_zigzag_scan
// Captures one 4x4 block of quantized coefficients and replays it one
// coefficient per beat in H.264 frame zigzag order. It also publishes the
// block's total_coeff and trailing_ones counts for the CAVLC stage.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | no block held; blk_ready_o=1 (unless h264_reset), no beats
// SCAN  | block held; coef_o shows zigzag position r_cnt, valid=1
//
// A last-beat handshake raises blk_ready_o for that cycle only. A block
// offered in that cycle is captured, and the scan restarts at position 0
// with no bubble between blocks.
module tq_zigzag_scan #(
    parameter int COEF_W = 15,
    parameter int TAG_W  = 4
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       h264_reset,
    input  logic                       blk_valid_i,
    output logic                       blk_ready_o,
    input  logic [16*COEF_W-1:0]       coeff_i,
    input  logic [TAG_W-1:0]           blk_tag_i,
    output logic                       coef_valid_o,
    input  logic                       coef_ready_i,
    output logic signed [COEF_W-1:0]   coef_o,
    output logic [3:0]                 coef_idx_o,
    output logic                       coef_last_o,
    output logic [TAG_W-1:0]           blk_tag_o,
    output logic [4:0]                 total_coeff_o,
    output logic [1:0]                 trailing_ones_o
);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SCAN = 1'b1
    } state_t;

    localparam logic [COEF_W-1:0] C_PLUS_ONE  = COEF_W'(1);
    localparam logic [COEF_W-1:0] C_MINUS_ONE = '1;

    // Maps a zigzag position to its raster index inside the 4x4 block.
    function automatic logic [3:0] zz_map(input logic [3:0] p);
        logic [3:0] r;
        case (p)
            4'd0:    r = 4'd0;
            4'd1:    r = 4'd1;
            4'd2:    r = 4'd4;
            4'd3:    r = 4'd8;
            4'd4:    r = 4'd5;
            4'd5:    r = 4'd2;
            4'd6:    r = 4'd3;
            4'd7:    r = 4'd6;
            4'd8:    r = 4'd9;
            4'd9:    r = 4'd12;
            4'd10:   r = 4'd13;
            4'd11:   r = 4'd10;
            4'd12:   r = 4'd7;
            4'd13:   r = 4'd11;
            4'd14:   r = 4'd14;
            default: r = 4'd15;
        endcase
        return r;
    endfunction

    state_t                 r_state;
    state_t                 w_state_nxt;
    logic [COEF_W-1:0]      r_buf [16];
    logic [3:0]             r_cnt;
    logic [TAG_W-1:0]       r_tag;
    logic [4:0]             r_total;
    logic [1:0]             r_t1;

    logic [COEF_W-1:0]      w_raster [16];
    logic [4:0]             w_total;
    logic [1:0]             w_t1;
    logic                   w_t1_stop;
    logic                   w_blk_ready;
    logic                   w_coef_valid;
    logic                   w_last;
    logic                   w_capture;
    logic                   w_beat;

    // Unpack the flat input bus into raster-indexed coefficients.
    always_comb begin
        for (int i = 0; i < 16; i++) begin
            w_raster[i] = coeff_i[i*COEF_W +: COEF_W];
        end
    end

    // Block statistics for CAVLC. Walk from zigzag position 15 down to 0.
    // Zeros are skipped. Trailing ones stop at the first magnitude >1 or
    // once three have been counted.
    always_comb begin
        w_total   = 5'd0;
        w_t1      = 2'd0;
        w_t1_stop = 1'b0;
        for (int p = 15; p >= 0; p--) begin
            if (w_raster[zz_map(4'(p))] != '0) begin
                w_total = w_total + 5'd1;
                if (!w_t1_stop) begin
                    if ((w_raster[zz_map(4'(p))] == C_PLUS_ONE) ||
                        (w_raster[zz_map(4'(p))] == C_MINUS_ONE)) begin
                        w_t1 = w_t1 + 2'd1;
                        if (w_t1 == 2'd3) begin
                            w_t1_stop = 1'b1;
                        end
                    end else begin
                        w_t1_stop = 1'b1;
                    end
                end
            end
        end
    end

    assign w_last = (r_cnt == 4'd15);

    // Next-state and handshake decode. Soft clear overrides everything.
    always_comb begin
        w_state_nxt  = r_state;
        w_blk_ready  = 1'b0;
        w_coef_valid = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_blk_ready = 1'b1;
                if (blk_valid_i) begin
                    w_state_nxt = ST_SCAN;
                end
            end
            ST_SCAN: begin
                w_coef_valid = 1'b1;
                if (w_last && coef_ready_i) begin
                    w_blk_ready = 1'b1;
                    if (!blk_valid_i) begin
                        w_state_nxt = ST_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
        if (h264_reset) begin
            w_blk_ready = 1'b0;
            w_state_nxt = ST_IDLE;
        end
    end

    assign w_capture = blk_valid_i && w_blk_ready;
    assign w_beat    = w_coef_valid && coef_ready_i;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Block buffer, tag, stats and scan position.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
            r_cnt   <= 4'd0;
            r_tag   <= '0;
            r_total <= 5'd0;
            r_t1    <= 2'd0;
        end else if (h264_reset) begin
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= '0;
            end
            r_cnt   <= 4'd0;
            r_tag   <= '0;
            r_total <= 5'd0;
            r_t1    <= 2'd0;
        end else if (w_capture) begin
            for (int i = 0; i < 16; i++) begin
                r_buf[i] <= w_raster[i];
            end
            r_cnt   <= 4'd0;
            r_tag   <= blk_tag_i;
            r_total <= w_total;
            r_t1    <= w_t1;
        end else if (w_beat) begin
            // Position 15 wraps back to 0, which leaves IDLE at position 0.
            r_cnt <= r_cnt + 4'd1;
        end
    end

    assign blk_ready_o     = w_blk_ready;
    assign coef_valid_o    = w_coef_valid;
    assign coef_o          = r_buf[zz_map(r_cnt)];
    assign coef_idx_o      = r_cnt;
    assign coef_last_o     = w_coef_valid && w_last;
    assign blk_tag_o       = r_tag;
    assign total_coeff_o   = r_total;
    assign trailing_ones_o = r_t1;

endmodule

// File: tb/tb_tq_zigzag_scan.sv
// Directed and randomized bench for tq_zigzag_scan. Blocks are held in
// zigzag-position order. Expected beats are the block values in order,
// and expected stats come straight from the CAVLC counting rules.
module tb_tq_zigzag_scan;

    logic                 clk;
    logic                 rst_n;
    logic                 h264_reset;
    logic                 blk_valid_i;
    logic                 blk_ready_o;
    logic [16*15-1:0]     coeff_i;
    logic [3:0]           blk_tag_i;
    logic                 coef_valid_o;
    logic                 coef_ready_i;
    logic signed [14:0]   coef_o;
    logic [3:0]           coef_idx_o;
    logic                 coef_last_o;
    logic [3:0]           blk_tag_o;
    logic [4:0]           total_coeff_o;
    logic [1:0]           trailing_ones_o;

    int n_chk;
    int n_fail;
    int ZZ [16] = '{0, 1, 4, 8, 5, 2, 3, 6, 9, 12, 13, 10, 7, 11, 14, 15};

    tq_zigzag_scan #(.COEF_W(15), .TAG_W(4)) dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .h264_reset      (h264_reset),
        .blk_valid_i     (blk_valid_i),
        .blk_ready_o     (blk_ready_o),
        .coeff_i         (coeff_i),
        .blk_tag_i       (blk_tag_i),
        .coef_valid_o    (coef_valid_o),
        .coef_ready_i    (coef_ready_i),
        .coef_o          (coef_o),
        .coef_idx_o      (coef_idx_o),
        .coef_last_o     (coef_last_o),
        .blk_tag_o       (blk_tag_o),
        .total_coeff_o   (total_coeff_o),
        .trailing_ones_o (trailing_ones_o)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: observed no end of test, expected finish");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic signed [31:0] obs,
                       input logic signed [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Place zigzag-ordered values at their raster slots on the input bus.
    task automatic load_bus(input int z[16]);
        for (int p = 0; p < 16; p++) begin
            coeff_i[ZZ[p]*15 +: 15] = 15'(z[p]);
        end
    endtask

    // total_coeff / trailing_ones from the rules: list nonzeros from the
    // highest position down, then count leading +/-1 entries up to 3.
    task automatic ref_stats(input int z[16], output int tc, output int t1);
        int q[$];
        bit stop;
        for (int p = 15; p >= 0; p--) begin
            if (z[p] != 0) q.push_back(z[p]);
        end
        tc = q.size();
        t1 = 0;
        stop = 0;
        for (int i = 0; i < q.size(); i++) begin
            if (!stop) begin
                if ((q[i] == 1 || q[i] == -1) && t1 < 3) t1++;
                else stop = 1;
            end
        end
    endtask

    task automatic gen(output int z[16], input bit sparse);
        for (int p = 0; p < 16; p++) begin
            int r;
            r = int'($urandom_range(0, 9));
            if (!sparse)     z[p] = int'($urandom_range(0, 32767)) - 16384;
            else if (r < 5)  z[p] = 0;
            else if (r == 5) z[p] = 1;
            else if (r == 6) z[p] = -1;
            else             z[p] = int'($urandom_range(0, 600)) - 300;
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Offer a block while IDLE; it must be accepted on the next edge.
    task automatic present(input int z[16], input logic [3:0] tag);
        load_bus(z);
        blk_tag_i    = tag;
        blk_valid_i  = 1'b1;
        coef_ready_i = 1'b0;
        @(negedge clk);
        chk("idle_blk_ready", blk_ready_o, 1);
        chk("idle_coef_valid", coef_valid_o, 0);
        step();
        blk_valid_i = 1'b0;
    endtask

    // Consume beats of the held block up to position stop_at.
    // mode 0: always ready, 1: ready 1,0,0 repeating, 2: random ready.
    // With b2b set, the next block is offered during the scan.
    task automatic drain(input int z[16], input logic [3:0] tag, input int mode,
                         input int stop_at, input bit b2b,
                         input int nz[16], input logic [3:0] ntag);
        int  k;
        int  cyc;
        int  tc;
        int  t1;
        bit  rdy;
        ref_stats(z, tc, t1);
        k = 0;
        cyc = 0;
        while (k < stop_at && cyc < 400) begin
            if (mode == 0)      rdy = 1'b1;
            else if (mode == 1) rdy = (cyc % 3 == 0);
            else                rdy = 1'($urandom_range(0, 1));
            coef_ready_i = rdy;
            blk_valid_i  = b2b;
            if (b2b) begin
                load_bus(nz);
                blk_tag_i = ntag;
            end
            @(negedge clk);
            chk("coef_valid", coef_valid_o, 1);
            chk("coef_val", coef_o, z[k]);
            chk("coef_idx", coef_idx_o, k);
            chk("coef_last", coef_last_o, (k == 15));
            chk("blk_tag", blk_tag_o, tag);
            chk("total_coeff", total_coeff_o, tc);
            chk("trailing_ones", trailing_ones_o, t1);
            chk("scan_blk_ready", blk_ready_o, (k == 15 && rdy));
            step();
            if (rdy) k++;
            cyc++;
        end
        chk("drain_beats", k, stop_at);
        blk_valid_i  = 1'b0;
        coef_ready_i = 1'b0;
    endtask

    task automatic chk_cleared(input string tag);
        chk({tag, "_valid"}, coef_valid_o, 0);
        chk({tag, "_coef"}, coef_o, 0);
        chk({tag, "_idx"}, coef_idx_o, 0);
        chk({tag, "_last"}, coef_last_o, 0);
        chk({tag, "_tag"}, blk_tag_o, 0);
        chk({tag, "_tc"}, total_coeff_o, 0);
        chk({tag, "_t1"}, trailing_ones_o, 0);
    endtask

    initial begin
        int a[16];
        int b[16];
        int c[16];
        int d[16];
        int cur[16];
        int nxt[16];
        logic [3:0] ctag;
        logic [3:0] ntag;
        bit b2b;

        n_chk = 0;
        n_fail = 0;
        rst_n = 1'b0;
        h264_reset = 1'b0;
        blk_valid_i = 1'b0;
        coef_ready_i = 1'b0;
        coeff_i = '0;
        blk_tag_i = '0;

        #12;
        chk_cleared("reset");
        #5 rst_n = 1'b1;
        step();
        @(negedge clk);
        chk("post_reset_blk_ready", blk_ready_o, 1);
        chk("post_reset_valid", coef_valid_o, 0);
        step();

        // Raster ramp, tag 5, always ready.
        for (int p = 0; p < 16; p++) a[p] = ZZ[p] + 1;
        present(a, 4'd5);
        drain(a, 4'd5, 0, 16, 0, a, 4'd0);
        @(negedge clk);
        chk("after_block_idle", coef_valid_o, 0);
        step();

        // Stats examples: first under 1,0,0 backpressure, then random ready.
        for (int p = 0; p < 16; p++) b[p] = 0;
        b[0] = 7; b[1] = -1; b[2] = 3; b[5] = 1; b[9] = -1; b[12] = 1;
        present(b, 4'd9);
        drain(b, 4'd9, 1, 16, 0, b, 4'd0);
        for (int p = 0; p < 16; p++) c[p] = 0;
        c[0] = 2; c[3] = -1; c[7] = 4;
        present(c, 4'd3);
        drain(c, 4'd3, 2, 16, 0, c, 4'd0);

        // All-zero block still yields 16 beats.
        for (int p = 0; p < 16; p++) d[p] = 0;
        present(d, 4'd15);
        drain(d, 4'd15, 0, 16, 0, d, 4'd0);

        // Back-to-back blocks with valid held high.
        gen(a, 1'b1);
        gen(b, 1'b0);
        present(a, 4'd1);
        drain(a, 4'd1, 0, 16, 1, b, 4'd2);
        drain(b, 4'd2, 0, 16, 0, b, 4'd0);

        // Soft clear at position 7 while a new block is offered.
        gen(a, 1'b1);
        gen(b, 1'b1);
        present(a, 4'd6);
        drain(a, 4'd6, 0, 7, 0, a, 4'd0);
        h264_reset = 1'b1;
        blk_valid_i = 1'b1;
        coef_ready_i = 1'b1;
        load_bus(b);
        blk_tag_i = 4'd12;
        @(negedge clk);
        chk("softclr_blk_ready", blk_ready_o, 0);
        chk("softclr_idx_before", coef_idx_o, 7);
        step();
        h264_reset = 1'b0;
        blk_valid_i = 1'b0;
        @(negedge clk);
        chk_cleared("softclr");
        chk("softclr_idle_ready", blk_ready_o, 1);
        step();
        present(b, 4'd12);
        drain(b, 4'd12, 2, 16, 0, b, 4'd0);

        // Asynchronous reset between edges mid-scan.
        gen(a, 1'b0);
        gen(c, 1'b1);
        present(a, 4'd8);
        drain(a, 4'd8, 0, 5, 0, a, 4'd0);
        coef_ready_i = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        chk_cleared("async_rst");
        #4 rst_n = 1'b1;
        step();
        present(c, 4'd4);
        drain(c, 4'd4, 2, 16, 0, c, 4'd0);

        // Randomized chain, sometimes back-to-back.
        gen(cur, 1'b1);
        ctag = 4'($urandom_range(0, 15));
        present(cur, ctag);
        for (int i = 0; i < 8; i++) begin
            gen(nxt, 1'($urandom_range(0, 1)));
            ntag = 4'($urandom_range(0, 15));
            b2b = (i < 7) && 1'($urandom_range(0, 1));
            drain(cur, ctag, int'($urandom_range(0, 2)), 16, b2b, nxt, ntag);
            if (!b2b && i < 7) present(nxt, ntag);
            cur = nxt;
            ctag = ntag;
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
